// File: rtl/slotmaker_config_responder.sv
// Responder side of the slotmaker config interface: shadow/active slot->card tables
// and a commit engine that pulses a per-slot reset for every slot whose card changes.
module slotmaker_config_responder #(
  parameter int NUM_SLOTS = 8,
  parameter int CARD_W = 8,
  parameter int RESET_CYCLES = 4,
  parameter logic [NUM_SLOTS*CARD_W-1:0] SLOT_DEFAULTS = 64'h0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    slot,
  input  logic [CARD_W-1:0]             card_i,
  input  logic                          wr,
  input  logic                          reconfig,
  output logic [CARD_W-1:0]             card_o,
  output logic [NUM_SLOTS*CARD_W-1:0]   active_cards,
  output logic [NUM_SLOTS-1:0]          slot_reset,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMP  = 3'd1,
    RST  = 3'd2,
    UPD  = 3'd3,
    NEXT = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [3:0] RST_LOAD = 4'(RESET_CYCLES - 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_SLOTS - 1);

  logic [NUM_SLOTS-1:0][CARD_W-1:0] shadow_r;
  logic [NUM_SLOTS-1:0][CARD_W-1:0] active_r;
  logic                             wr_q_r;
  state_t                           state_r;
  logic [2:0]                       idx_r;
  logic [3:0]                       cnt_r;
  logic                             pending_r;
  logic                             wr_evt_s;
  logic                             wr_cfg_s;
  logic                             cmt_req_s;
  logic [CARD_W-1:0]                upd_card_s;

  // One action per wr high period; reconfig decides table write vs commit request.
  assign wr_evt_s   = wr & ~wr_q_r;
  assign wr_cfg_s   = wr_evt_s & ~reconfig;
  assign cmt_req_s  = wr_evt_s & reconfig;
  assign active_cards = active_r;

  // UPD takes the live shadow, including a write landing on the same edge.
  always_comb begin
    upd_card_s = shadow_r[idx_r];
    if (wr_cfg_s && (slot == idx_r)) begin
      upd_card_s = card_i;
    end else begin
      upd_card_s = shadow_r[idx_r];
    end
  end

  // Shadow table, write edge detect and registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q_r   <= 1'b0;
      shadow_r <= SLOT_DEFAULTS;
      card_o   <= SLOT_DEFAULTS[CARD_W-1:0];
    end else begin
      wr_q_r <= wr;
      if (wr_cfg_s) begin
        shadow_r[slot] <= card_i;
      end
      card_o <= shadow_r[slot];
    end
  end

  // Commit engine: walks every slot, resetting and updating the ones that changed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      idx_r      <= 3'd0;
      cnt_r      <= 4'd0;
      pending_r  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      slot_reset <= '0;
      active_r   <= SLOT_DEFAULTS;
    end else begin
      done <= 1'b0;
      if (cmt_req_s && (state_r inside {CMP, RST, UPD, NEXT})) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (cmt_req_s) begin
            state_r <= CMP;
            idx_r   <= 3'd0;
            busy    <= 1'b1;
          end
        end
        CMP: begin
          if (shadow_r[idx_r] != active_r[idx_r]) begin
            cnt_r              <= RST_LOAD;
            slot_reset[idx_r]  <= 1'b1;
            active_r[idx_r]    <= '0;
            state_r            <= RST;
          end else begin
            state_r <= NEXT;
          end
        end
        RST: begin
          if (cnt_r == 4'd0) begin
            slot_reset <= '0;
            state_r    <= UPD;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        UPD: begin
          active_r[idx_r] <= upd_card_s;
          state_r         <= NEXT;
        end
        NEXT: begin
          if (idx_r == LAST_IDX) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + 3'd1;
            state_r <= CMP;
          end
        end
        DONE: begin
          // A request arriving here with one already pending folds into that single pass.
          if (pending_r || cmt_req_s) begin
            pending_r <= 1'b0;
            idx_r     <= 3'd0;
            busy      <= 1'b1;
            state_r   <= CMP;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          busy       <= 1'b0;
          slot_reset <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/slotmaker_config_responder.md
Name: slotmaker_config_responder

Overview:
- Responder end of the slotmaker configuration interface. Receives the slot/card write and reconfig strobes that the PicoSoC config peripheral drives.
- Holds an 8-entry shadow slot→card table and an 8-entry active table.
- On reconfig, a commit FSM copies shadow to active slot by slot. Each slot whose card ID changes gets a reset pulse.
- Sits between the PicoSoC-side controller and the per-slot card instances in the A2FPGA core.

Parameters:
- NUM_SLOTS, 8, slot count; slot index width is 3 and is fixed.
- CARD_W, 8, card ID width.
- RESET_CYCLES, 4, width of the slot_reset pulse in clk cycles; legal range 1..15.
- SLOT_DEFAULTS, 64'h0, reset value of both tables; slot n is bits [8n+7:8n].

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- slot  in  3  table index for write/read
- card_i  in  8  card ID to write
- wr  in  1  write strobe; level, may stay high for several cycles per transaction
- reconfig  in  1  qualifies wr as a commit command
- card_o  out  8  shadow[slot], registered
- active_cards  out  64  active table, slot n at [8n+7:8n]
- slot_reset  out  8  per-slot reset, one-hot while asserted
- busy  out  1  commit in progress
- done  out  1  single-cycle pulse when a commit completes

Behaviour:
- Reset (async): shadow = active = SLOT_DEFAULTS; card_o = SLOT_DEFAULTS[7:0]; slot_reset = 0; busy = 0; done = 0; pending = 0; FSM = IDLE.
- Edge detect: wr_q is the registered wr. Event = wr & ~wr_q. Exactly one action per wr high period, regardless of its length.
- Write event with reconfig = 0: shadow[slot] <= card_i on the next edge. Accepted in any FSM state.
- Write event with reconfig = 1: commit request; table is not written. In IDLE, go to CMP with idx = 0 next cycle. Otherwise set pending.
- card_o: registered every cycle from shadow[slot]. One-cycle latency. Reflects a same-cycle write one cycle later.
- FSM states:
  - IDLE: busy = 0.
  - CMP: busy = 1. If shadow[idx] != active[idx], load cnt = RESET_CYCLES-1 and go to RST. Otherwise go to NEXT.
  - RST: slot_reset[idx] = 1; active[idx] = 0 during reset; decrement cnt. At cnt = 0 go to UPD.
  - UPD: active[idx] <= shadow[idx]; go to NEXT.
  - NEXT: if idx = 7 go to DONE, else idx+1 and go to CMP.
  - DONE: done = 1 for one cycle. If pending, clear it and go to CMP with idx = 0. Otherwise go to IDLE.
- Commit length: unchanged table = 16 cycles (CMP+NEXT ×8) + 1 DONE. Each changed slot adds RESET_CYCLES+1.
- Writes during a commit:
  - To slot > idx: picked up in this pass.
  - To slot ≤ idx: held in shadow until the next commit.
  - A shadow write to idx while in RST/UPD is visible to UPD (UPD uses the live shadow).
- Simultaneous events: a reconfig event in DONE with pending already set is absorbed, so at most one extra pass runs.
- Reset mid-commit: everything returns to reset values immediately, slot_reset included. No done pulse.
- active_cards and slot_reset are registered outputs with no combinational paths from inputs.

Test Plan:
- Reset with SLOT_DEFAULTS = 64'h0706050403020100 → active_cards equals that value; card_o = 8'h00; busy = 0; slot_reset = 0.
- wr high 5 cycles, slot = 3, card_i = 8'h2A, reconfig = 0 → shadow[3] = 8'h2A written once; card_o = 8'h2A one cycle after slot = 3 is presented; active unchanged.
- Then a reconfig event → busy rises the next cycle; slot_reset = 8'b0000_1000 for exactly 4 cycles; active[3] = 8'h00 during reset, then 8'h2A; done pulses once; total busy = 16 + 5 = 21 cycles.
- Reconfig with shadow equal to active → no slot_reset; busy for 16 cycles; done pulses once.
- During a commit with idx = 2: write slot 6 = 8'h11, write slot 1 = 8'h22, then reconfig → first pass updates slot 6 only; done pulses; second pass updates slot 1; done pulses a second time; then IDLE.
- Assert reset during RST for slot 5 → slot_reset = 0 and busy = 0 immediately; active = SLOT_DEFAULTS; no done pulse.
